// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, FSM state encodings and helpers for the register-file write-port arbiter.
// The state encodings are exported so the hazard unit can decode alu_stall sources consistently.
package wb_port_arbiter_pkg;

  localparam int WB_DSIZE = 32;
  localparam int WB_ASIZE = 5;

  localparam logic WB_S_EMPTY = 1'b0;
  localparam logic WB_S_HELD  = 1'b1;

  typedef enum logic {
    S_EMPTY = WB_S_EMPTY,
    S_HELD  = WB_S_HELD
  } wb_state_e;

  // Saturating increment used by the optional conflict counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the ALU, load-unit and register-file write signals around the write-port arbiter.
// slave = arbiter side, master = pipeline/load-unit/register-file side.
interface wb_port_arbiter_if #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5
);
  logic             alu_valid;
  logic [DSIZE-1:0] alu_data;
  logic [ASIZE-1:0] alu_waddr;
  logic             alu_stall;
  logic             ld_valid;
  logic [DSIZE-1:0] ld_data;
  logic [ASIZE-1:0] ld_waddr;
  logic             ld_ready;
  logic             wen;
  logic [ASIZE-1:0] waddr;
  logic [DSIZE-1:0] wdata;

  modport slave (
    input  alu_valid, alu_data, alu_waddr,
    input  ld_valid, ld_data, ld_waddr,
    output alu_stall, ld_ready,
    output wen, waddr, wdata
  );

  modport master (
    output alu_valid, alu_data, alu_waddr,
    output ld_valid, ld_data, ld_waddr,
    input  alu_stall, ld_ready,
    input  wen, waddr, wdata
  );
endinterface

// File: rtl/wb_port_arbiter_hold_reg.sv
// One-entry {valid, addr, data} buffer (wb_hold_reg) holding an ALU result deferred by a load.
// clear_i wins over load_i; reset is asynchronous and empties the entry.
module wb_port_arbiter_hold_reg #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [ASIZE-1:0] addr_i,
  input  logic [DSIZE-1:0] data_i,
  output logic             valid_o,
  output logic [ASIZE-1:0] addr_o,
  output logic [DSIZE-1:0] data_o
);

  logic             valid_q;
  logic [ASIZE-1:0] addr_q;
  logic [DSIZE-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: held ALU entry > load > incoming ALU, registered write outputs.
// Optional build macro WB_CONFLICT_CNT_EN adds a saturating 16-bit collision counter output.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DSIZE = WB_DSIZE,
  parameter int ASIZE = WB_ASIZE
) (
  input  logic                clk,
  input  logic                rst,
  wb_port_arbiter_if.slave    bus
`ifdef WB_CONFLICT_CNT_EN
  ,
  output logic [15:0]         conflict_cnt
`endif
);

  wb_state_e        state_q, state_d;
  logic             wen_q;
  logic [ASIZE-1:0] waddr_q;
  logic [DSIZE-1:0] wdata_q;

  logic             hold_valid;
  logic [ASIZE-1:0] hold_addr;
  logic [DSIZE-1:0] hold_data;
  logic             hold_load_d, hold_clear_d;

  logic             grant_d;
  logic [ASIZE-1:0] gaddr_d;
  logic [DSIZE-1:0] gdata_d;

  wb_port_arbiter_hold_reg #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load_i  (hold_load_d),
    .clear_i (hold_clear_d),
    .addr_i  (bus.alu_waddr),
    .data_i  (bus.alu_data),
    .valid_o (hold_valid),
    .addr_o  (hold_addr),
    .data_o  (hold_data)
  );

  // In HELD the ALU input is frozen upstream and the load is refused, so only the held entry matters.
  always_comb begin
    state_d      = state_q;
    grant_d      = 1'b0;
    gaddr_d      = '0;
    gdata_d      = '0;
    hold_load_d  = 1'b0;
    hold_clear_d = 1'b0;
    case (state_q)
      S_HELD: begin
        grant_d      = hold_valid;
        gaddr_d      = hold_addr;
        gdata_d      = hold_data;
        hold_clear_d = 1'b1;
        state_d      = S_EMPTY;
      end
      default: begin
        if (bus.ld_valid) begin
          grant_d = 1'b1;
          gaddr_d = bus.ld_waddr;
          gdata_d = bus.ld_data;
          if (bus.alu_valid) begin
            hold_load_d = 1'b1;
            state_d     = S_HELD;
          end
        end else if (bus.alu_valid) begin
          grant_d = 1'b1;
          gaddr_d = bus.alu_waddr;
          gdata_d = bus.alu_data;
        end
      end
    endcase
  end

  // r0 is hardwired: the beat is consumed and address/data still track it, only wen is masked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= grant_d && (gaddr_d != '0);
      if (grant_d) begin
        waddr_q <= gaddr_d;
        wdata_q <= gdata_d;
      end
    end
  end

  assign bus.alu_stall = (state_q == S_HELD);
  assign bus.ld_ready  = (state_q == S_EMPTY);
  assign bus.wen       = wen_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;

`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt_q <= 16'd0;
    end else if (state_q == S_EMPTY && state_d == S_HELD) begin
      conflict_cnt_q <= sat_inc16(conflict_cnt_q);
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table with a write scoreboard plus
// hand sequences for back-to-back collisions and mid-operation reset.
module tb_wb_port_arbiter;

  logic clk;
  logic rst;

  wb_port_arbiter_if #(.DSIZE(32), .ASIZE(5)) bus ();

`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  wb_port_arbiter #(.DSIZE(32), .ASIZE(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef WB_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ldv;
    logic [4:0]  lda;
    logic [31:0] ldd;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        exp_stall;
    logic        exp_ready;
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct packed {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wr_t;

  vec_t tbl [13];
  wr_t  exp_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic drive(input logic ldv, input logic [4:0] lda, input logic [31:0] ldd,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    bus.ld_valid  = ldv;
    bus.ld_waddr  = lda;
    bus.ld_data   = ldd;
    bus.alu_valid = av;
    bus.alu_waddr = aa;
    bus.alu_data  = ad;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic check_write(input string name);
    wr_t e, a;
    checks++;
    a = '{wen: bus.wen, waddr: bus.waddr, wdata: bus.wdata};
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got wen=%b waddr=%0d wdata=%h expected nothing queued", name, a.wen, a.waddr, a.wdata);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got wen=%b waddr=%0d wdata=%h expected wen=%b waddr=%0d wdata=%h",
                 name, a.wen, a.waddr, a.wdata, e.wen, e.waddr, e.wdata);
      end else begin
        $display("ok   %s: wen=%b waddr=%0d wdata=%h", name, a.wen, a.waddr, a.wdata);
      end
    end
  endtask

  initial begin
    //          ldv   lda    ldd        av    aa     ad         stall ready wen   waddr  wdata
    tbl[0]  = '{1'b0, 5'd0,  32'h0,     1'b1, 5'd5,  32'h1234,  1'b0, 1'b1, 1'b1, 5'd5,  32'h1234};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b0, 1'b1, 1'b0, 5'd5,  32'h1234};
    tbl[2]  = '{1'b1, 5'd7,  32'hBBBB,  1'b1, 5'd3,  32'hAAAA,  1'b0, 1'b1, 1'b1, 5'd7,  32'hBBBB};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,     1'b1, 5'd3,  32'hAAAA,  1'b1, 1'b0, 1'b1, 5'd3,  32'hAAAA};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b0, 1'b1, 1'b0, 5'd3,  32'hAAAA};
    tbl[5]  = '{1'b1, 5'd0,  32'hFFFF,  1'b0, 5'd0,  32'h0,     1'b0, 1'b1, 1'b0, 5'd0,  32'hFFFF};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,     1'b1, 5'd0,  32'h5555,  1'b0, 1'b1, 1'b0, 5'd0,  32'h5555};
    tbl[7]  = '{1'b1, 5'd9,  32'h11,    1'b0, 5'd0,  32'h0,     1'b0, 1'b1, 1'b1, 5'd9,  32'h11};
    tbl[8]  = '{1'b1, 5'd4,  32'h44,    1'b1, 5'd0,  32'h22,    1'b0, 1'b1, 1'b1, 5'd4,  32'h44};
    tbl[9]  = '{1'b1, 5'd6,  32'h66,    1'b1, 5'd0,  32'h22,    1'b1, 1'b0, 1'b0, 5'd0,  32'h22};
    tbl[10] = '{1'b1, 5'd6,  32'h66,    1'b1, 5'd1,  32'h77,    1'b0, 1'b1, 1'b1, 5'd6,  32'h66};
    tbl[11] = '{1'b0, 5'd0,  32'h0,     1'b1, 5'd1,  32'h77,    1'b1, 1'b0, 1'b1, 5'd1,  32'h77};
    tbl[12] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     1'b0, 1'b1, 1'b0, 5'd1,  32'h77};

    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wen", {31'd0, bus.wen}, 32'd0);
    chk("reset_waddr", {27'd0, bus.waddr}, 32'd0);
    chk("reset_wdata", bus.wdata, 32'd0);
    chk("reset_stall", {31'd0, bus.alu_stall}, 32'd0);
    chk("reset_ready", {31'd0, bus.ld_ready}, 32'd1);
`ifdef WB_CONFLICT_CNT_EN
    chk("reset_cnt", {16'd0, conflict_cnt}, 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].ldv, tbl[i].lda, tbl[i].ldd, tbl[i].av, tbl[i].aa, tbl[i].ad);
      chk($sformatf("vec%0d_stall", i), {31'd0, bus.alu_stall}, {31'd0, tbl[i].exp_stall});
      chk($sformatf("vec%0d_ready", i), {31'd0, bus.ld_ready}, {31'd0, tbl[i].exp_ready});
      exp_q.push_back('{wen: tbl[i].exp_wen, waddr: tbl[i].exp_waddr, wdata: tbl[i].exp_wdata});
      @(posedge clk);
      #1;
      check_write($sformatf("vec%0d_write", i));
    end

    // Back-to-back collisions: both producers always valid and advance on acceptance.
    begin
      int li, ai;
      logic rdy, stl;
      li = 0;
      ai = 0;
      for (int k = 0; k < 6; k++) begin
        drive(1'b1, 5'(li + 1), 32'h1000 + 32'(li), 1'b1, 5'(10 + ai), 32'h2000 + 32'(ai));
        rdy = bus.ld_ready;
        stl = bus.alu_stall;
        chk($sformatf("b2b%0d_ready", k), {31'd0, rdy}, (k % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("b2b%0d_stall", k), {31'd0, stl}, (k % 2 == 0) ? 32'd0 : 32'd1);
        if (k % 2 == 0)
          exp_q.push_back('{wen: 1'b1, waddr: 5'(k / 2 + 1), wdata: 32'h1000 + 32'(k / 2)});
        else
          exp_q.push_back('{wen: 1'b1, waddr: 5'(10 + (k - 1) / 2), wdata: 32'h2000 + 32'((k - 1) / 2)});
        @(posedge clk);
        #1;
        if (rdy) li++;
        if (!stl) ai++;
        check_write($sformatf("b2b%0d_write", k));
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      exp_q.push_back('{wen: 1'b0, waddr: 5'd12, wdata: 32'h2002});
      @(posedge clk);
      #1;
      check_write("b2b_idle_write");
    end

`ifdef WB_CONFLICT_CNT_EN
    chk("conflict_cnt", {16'd0, conflict_cnt}, 32'd6);
`endif

    // Reset while a deferred ALU result is held.
    drive(1'b1, 5'd2, 32'hC0DE, 1'b1, 5'd8, 32'hBEEF);
    exp_q.push_back('{wen: 1'b1, waddr: 5'd2, wdata: 32'hC0DE});
    @(posedge clk);
    #1;
    check_write("prerst_write");
    chk("prerst_stall", {31'd0, bus.alu_stall}, 32'd1);
    bus.ld_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_wen", {31'd0, bus.wen}, 32'd0);
    chk("midrst_waddr", {27'd0, bus.waddr}, 32'd0);
    chk("midrst_wdata", bus.wdata, 32'd0);
    chk("midrst_stall", {31'd0, bus.alu_stall}, 32'd0);
    chk("midrst_ready", {31'd0, bus.ld_ready}, 32'd1);
`ifdef WB_CONFLICT_CNT_EN
    chk("midrst_cnt", {16'd0, conflict_cnt}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back('{wen: 1'b1, waddr: 5'd8, wdata: 32'hBEEF});
    @(posedge clk);
    #1;
    check_write("postrst_write");
    chk("postrst_stall", {31'd0, bus.alu_stall}, 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two producers:
  - the ALU result leaving the EXE/WB pipeline register;
  - the multi-cycle load unit's returning data.
- Arbitrates each cycle and holds one deferred ALU result in a one-entry buffer.
- Stalls the pipeline front end while that buffer is occupied.
- Drives registered wen/waddr/wdata into the register file.

Parameters:
- DSIZE, 32, data width (matches `DSIZE in define.v).
- ASIZE, 5, register address width (matches `ASIZE in define.v).

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous reset, active-high.
- alu_valid  input  1  EXE/WB stage carries a result to write.
- alu_data  input  DSIZE  ALU result.
- alu_waddr  input  ASIZE  destination register of ALU result.
- alu_stall  output  1  freeze IF/ID/EXE and the EXE/WB register this cycle.
- ld_valid  input  1  load unit presents returning data.
- ld_data  input  DSIZE  load data.
- ld_waddr  input  ASIZE  load destination register.
- ld_ready  output  1  load beat accepted this cycle when ld_valid is also high.
- wen  output  1  register-file write enable (registered).
- waddr  output  ASIZE  register-file write address (registered).
- wdata  output  DSIZE  register-file write data (registered).

Behaviour:
- One clock; reset is asynchronous and active-high. While rst is high: state=EMPTY, hold cleared, wen=0, waddr=0, wdata=0.
- FSM states:
  - EMPTY: hold buffer free.
  - HELD: hold buffer has a deferred ALU result.
- alu_stall = (state==HELD); this is a Moore output.
- ld_ready = (state==EMPTY); this is a Moore output.
- ALU beat accept: an ALU beat is consumed when alu_valid && !alu_stall. While stalled, upstream holds alu_* stable and the arbiter ignores it.
- Grant priority per cycle: held entry > load > incoming ALU.
- In EMPTY:
  - ld_valid only: write load; stay EMPTY.
  - alu_valid only: write ALU; stay EMPTY.
  - both: write load, capture ALU into hold, go HELD.
  - neither: wen=0 next cycle; stay EMPTY.
- In HELD:
  - Write the held entry.
  - Go EMPTY.
  - Load is not accepted (ld_ready=0).
  - ALU input is frozen.
- Write timing: the write appears on wen/waddr/wdata on the clock edge after the grant cycle (1-cycle latency).
- Idle cycles: wen drops to 0; waddr/wdata keep their last values.
- Register 0: a granted beat with address 0 is consumed normally, but wen stays 0 (r0 hardwired). waddr/wdata still update.
- Ordering: the held ALU entry is older than any later load, so it always writes first. Same-address collisions therefore resolve oldest-first, with no special casing.
- Throughput:
  - One write per cycle maximum.
  - A collision costs exactly one stall cycle.
  - The load is never blocked more than one cycle in a row.
- Reset mid-operation: hold contents are discarded. A write registered but not yet observed is cleared; wen=0 after reset.

Optional Feature:
- Macro: WB_CONFLICT_CNT_EN.
- When defined:
  - Adds output port conflict_cnt [15:0], reset to 0.
  - Increments on every EMPTY->HELD transition.
  - Saturates at 16'hFFFF.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- DSIZE/ASIZE come from shared define.v.
- Add `WB_S_EMPTY / `WB_S_HELD state encodings (1 bit) to define.v for reuse by the hazard unit.
- Natural sub-module: wb_hold_reg.
  - One-entry register {valid, addr, data} with load/clear inputs.
  - Asynchronous reset.
- Arbitration and output register stay in the top module.

Test Plan:
- Reset: assert rst mid-stream with alu_valid=1 -> wen=0, waddr=0, wdata=0 and alu_stall=0 immediately; ld_ready=1.
- ALU only: alu_valid=1, alu_waddr=5, alu_data=32'h1234 -> next cycle wen=1, waddr=5, wdata=32'h1234; alu_stall stays 0.
- Collision:
  - Stimulus: cycle N has alu (r3, 32'hAAAA) and ld (r7, 32'hBBBB).
  - N+1: r7=BBBB written, alu_stall=1, ld_ready=0.
  - N+2: r3=AAAA written, alu_stall=0.
  - With WB_CONFLICT_CNT_EN: conflict_cnt=1.
- Back-to-back collisions: ld_valid held 1 and alu_valid held 1 for 6 cycles -> writes alternate ld/alu, no beat lost or duplicated, ld_ready toggles 1,0,1,0.
- r0 suppression: ld_valid=1, ld_waddr=0, ld_data=32'hFFFF -> ld_ready=1, next cycle wen=0, waddr=0.
- Counter saturation (WB_CONFLICT_CNT_EN): force 65536 collisions -> conflict_cnt holds 16'hFFFF.
